// File: rtl/cell_window_generator_pkg.sv
// Shared types and constants for the cell window generator and its consumer.
package cell_window_generator_pkg;

  localparam int MATRIX_DIM  = 3;
  localparam int centerPixel = 1;

  typedef logic [7:0] pixel_t;

  // pixelMatrix[r][c]: r=0 is the oldest row, c=0 the leftmost column
  typedef pixel_t [MATRIX_DIM-1:0][MATRIX_DIM-1:0] cell_t;

  typedef enum logic [2:0] {
    NOP, ADD, SUB, ADDI, SUBI, MUL, MAX, MIN
  } opcodes_t;

  typedef struct packed {
    opcodes_t opcode;
    cell_t    cellA;
    cell_t    cellB;
    pixel_t   userInputA;
  } iw_t;

  typedef enum logic {IDLE, ACTIVE} gen_state_t;

endpackage

// File: rtl/cell_window_generator_line_buffer.sv
// Single-row delay: circular RAM, read-before-write at the write pointer.
module line_buffer
  import cell_window_generator_pkg::*;
#(
  parameter int DEPTH = 64
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   en,
  input  pixel_t din,
  output pixel_t dout
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  pixel_t          mem [DEPTH];
  logic [AW-1:0]   wptr;

  // Old entry at the pointer is the pixel written DEPTH accepts ago
  assign dout = mem[wptr];

  // Storage: contents need no reset
  always_ff @(posedge clk) begin
    if (en) mem[wptr] <= din;
  end

  // Write pointer wraps at DEPTH-1
  always_ff @(posedge clk or posedge rst) begin
    if (rst)     wptr <= '0;
    else if (en) wptr <= (wptr == AW'(DEPTH-1)) ? '0 : wptr + 1'b1;
  end

endmodule

// File: rtl/cell_window_generator.sv
// Raster pixel stream (channels A/B) -> 3x3 instruction words for the processor.
module cell_window_generator
  import cell_window_generator_pkg::*;
#(
  parameter int IMG_WIDTH  = 64,
  parameter int IMG_HEIGHT = 64
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          pix_valid,
  output logic                          pix_ready,
  input  logic                          pix_sof,
  input  pixel_t                        pix_a,
  input  pixel_t                        pix_b,
  input  opcodes_t                      cfg_opcode,
  input  pixel_t                        cfg_user_a,
  output logic                          iw_valid,
  input  logic                          iw_ready,
  output iw_t                           iw,
  output logic [$clog2(IMG_WIDTH)-1:0]  iw_x,
  output logic [$clog2(IMG_HEIGHT)-1:0] iw_y,
  output logic                          iw_last,
  output logic                          frame_done,
  output logic                          frame_err
);

  localparam int XW = $clog2(IMG_WIDTH);
  localparam int YW = $clog2(IMG_HEIGHT);
  localparam int NCH = 2;

  gen_state_t           state, nstate;
  logic [XW-1:0]        x, cx;
  logic [YW-1:0]        y, cy;
  opcodes_t             opcode_q;
  pixel_t               user_q;
  logic                 acc, in_frame, err, eol, eof, emit;

  pixel_t [NCH-1:0]     pin, row1, row2;
  cell_t  [NCH-1:0]     win, nxt;

  assign pix_ready = !iw_valid || iw_ready;
  assign acc       = pix_valid && pix_ready;
  assign pin       = {pix_b, pix_a};

  // Two chained row delays per channel: row1 = y-1, row2 = y-2
  line_buffer #(.DEPTH(IMG_WIDTH)) u_lb0 [NCH-1:0] (
    .clk(clk), .rst(rst), .en(in_frame), .din(pin),  .dout(row1));
  line_buffer #(.DEPTH(IMG_WIDTH)) u_lb1 [NCH-1:0] (
    .clk(clk), .rst(rst), .en(in_frame), .din(row1), .dout(row2));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nstate;
  end

  // Next state: last pixel returns to IDLE, any in-frame pixel keeps/starts ACTIVE
  always_comb begin
    nstate = state;
    if (in_frame) nstate = eof ? IDLE : ACTIVE;
  end

  // Decode of the accepted pixel; an sof pixel is always (0,0)
  always_comb begin
    in_frame = acc && (state == ACTIVE || pix_sof);
    err      = acc && ((state == IDLE) != pix_sof);
    cx       = (state == IDLE || pix_sof) ? '0 : x;
    cy       = (state == IDLE || pix_sof) ? '0 : y;
    eol      = (cx == XW'(IMG_WIDTH-1));
    eof      = eol && (cy == YW'(IMG_HEIGHT-1));
    emit     = in_frame && (cx >= XW'(2)) && (cy >= YW'(2));
  end

  // Window after this pixel: shift left, new column enters on the right
  always_comb begin
    nxt = win;
    for (int ch = 0; ch < NCH; ch++) begin
      for (int r = 0; r < MATRIX_DIM; r++)
        for (int c = 0; c < MATRIX_DIM-1; c++)
          nxt[ch][r][c] = win[ch][r][c+1];
      nxt[ch][0][MATRIX_DIM-1] = row2[ch];
      nxt[ch][1][MATRIX_DIM-1] = row1[ch];
      nxt[ch][2][MATRIX_DIM-1] = pin[ch];
    end
  end

  // Shift window storage; stale columns across row wrap are never emitted
  always_ff @(posedge clk) begin
    if (in_frame) win <= nxt;
  end

  // Position counters and frame-latched configuration
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x        <= '0;
      y        <= '0;
      opcode_q <= NOP;
      user_q   <= '0;
    end else if (in_frame) begin
      if (pix_sof) begin
        opcode_q <= cfg_opcode;
        user_q   <= cfg_user_a;
      end
      if (eof) begin
        x <= '0;
        y <= '0;
      end else if (eol) begin
        x <= '0;
        y <= cy + 1'b1;
      end else begin
        x <= cx + 1'b1;
        y <= cy;
      end
    end
  end

  // Output register: reload on emit, otherwise drop valid once consumed
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      iw_valid   <= 1'b0;
      iw         <= '0;
      iw_x       <= '0;
      iw_y       <= '0;
      iw_last    <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      frame_done <= in_frame && eof;
      frame_err  <= err;
      if (emit) begin
        iw_valid      <= 1'b1;
        iw.opcode     <= opcode_q;
        iw.cellA      <= nxt[0];
        iw.cellB      <= nxt[1];
        iw.userInputA <= user_q;
        iw_x          <= cx - XW'(MATRIX_DIM-1-centerPixel);
        iw_y          <= cy - YW'(MATRIX_DIM-1-centerPixel);
        iw_last       <= eof;
      end else if (iw_ready) begin
        iw_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cell_window_generator.sv
// Directed bench for cell_window_generator at W=5, H=4.
module tb_cell_window_generator;
  import cell_window_generator_pkg::*;

  localparam int W = 5;
  localparam int H = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       pix_valid, pix_ready, pix_sof;
  pixel_t     pix_a, pix_b, cfg_user_a;
  opcodes_t   cfg_opcode;
  logic       iw_valid, iw_ready, iw_last, frame_done, frame_err;
  iw_t        iw;
  logic [2:0] iw_x;
  logic [1:0] iw_y;

  cell_window_generator #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk(clk), .rst(rst), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_sof(pix_sof), .pix_a(pix_a), .pix_b(pix_b),
    .cfg_opcode(cfg_opcode), .cfg_user_a(cfg_user_a),
    .iw_valid(iw_valid), .iw_ready(iw_ready), .iw(iw),
    .iw_x(iw_x), .iw_y(iw_y), .iw_last(iw_last),
    .frame_done(frame_done), .frame_err(frame_err));

  always #5 clk = ~clk;

  typedef struct { int cx; int cy; bit last; } vec_t;
  typedef struct { iw_t w; int x; int y; bit last; } cap_t;

  vec_t tbl [6];
  cap_t cap [$];
  int   nd, ne;
  int   checks = 0, failures = 0;

  // Monitor: transfers on iw_valid&&iw_ready plus pulse counts
  always @(negedge clk) begin
    if (!rst) begin
      if (iw_valid && iw_ready) begin
        cap_t c;
        c.w = iw; c.x = int'(iw_x); c.y = int'(iw_y); c.last = iw_last;
        cap.push_back(c);
      end
      if (frame_done) nd++;
      if (frame_err)  ne++;
    end
  end

  task automatic chk(string nm, logic [159:0] act, logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  function automatic cell_t mk_cell(int cx, int cy, bit chb);
    cell_t  cl;
    pixel_t p;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) begin
        p = pixel_t'(16*(cy-1+r) + (cx-1+c));
        cl[r][c] = chb ? 8'd255 - p : p;
      end
    return cl;
  endfunction

  // Called at a negedge; returns at the negedge after acceptance
  task automatic send_px(int x, int y, bit sof, bit old);
    bit ok = 0;
    pix_a     = old ? pixel_t'(192 + 8*y + x) : pixel_t'(16*y + x);
    pix_b     = 8'd255 - pix_a;
    pix_sof   = sof;
    pix_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (pix_ready) begin
        @(posedge clk);
        @(negedge clk);
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) chk("send_timeout", 160'(0), 160'(1));
  endtask

  task automatic idle_in(int n);
    pix_valid = 1'b0;
    pix_sof   = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(opcodes_t op, pixel_t ua);
    cfg_opcode = op;
    cfg_user_a = ua;
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) begin
        send_px(x, y, (x == 0 && y == 0), 1'b0);
        cfg_opcode = SUB;
        cfg_user_a = 8'd99;
      end
    idle_in(3);
  endtask

  task automatic clear_mon();
    cap.delete();
    nd = 0;
    ne = 0;
  endtask

  task automatic check_frame(string tag, opcodes_t op, pixel_t ua, int exp_nd, int exp_ne);
    chk({tag, "_count"}, 160'(cap.size()), 160'(6));
    for (int i = 0; i < 6 && i < cap.size(); i++) begin
      chk($sformatf("%s_x%0d", tag, i),     160'(cap[i].x),    160'(tbl[i].cx));
      chk($sformatf("%s_y%0d", tag, i),     160'(cap[i].y),    160'(tbl[i].cy));
      chk($sformatf("%s_last%0d", tag, i),  160'(cap[i].last), 160'(tbl[i].last));
      chk($sformatf("%s_cellA%0d", tag, i), 160'(cap[i].w.cellA), 160'(mk_cell(tbl[i].cx, tbl[i].cy, 1'b0)));
      chk($sformatf("%s_cellB%0d", tag, i), 160'(cap[i].w.cellB), 160'(mk_cell(tbl[i].cx, tbl[i].cy, 1'b1)));
      chk($sformatf("%s_op%0d", tag, i),    160'(cap[i].w.opcode), 160'(op));
      chk($sformatf("%s_ua%0d", tag, i),    160'(cap[i].w.userInputA), 160'(ua));
    end
    chk({tag, "_done"}, 160'(nd), 160'(exp_nd));
    chk({tag, "_err"},  160'(ne), 160'(exp_ne));
  endtask

  initial begin
    cell_t first;
    logic [1:0] sy;
    logic [2:0] sx;
    iw_t  snap;
    bit   ok;

    tbl[0] = '{1, 1, 0}; tbl[1] = '{2, 1, 0}; tbl[2] = '{3, 1, 0};
    tbl[3] = '{1, 2, 0}; tbl[4] = '{2, 2, 0}; tbl[5] = '{3, 2, 1};

    rst = 1'b1; pix_valid = 0; pix_sof = 0; pix_a = 0; pix_b = 0;
    cfg_opcode = NOP; cfg_user_a = 0; iw_ready = 1'b1;
    nd = 0; ne = 0;
    repeat (2) @(negedge clk);

    // Reset state
    chk("rst_iw_valid",   160'(iw_valid),   160'(0));
    chk("rst_pix_ready",  160'(pix_ready),  160'(1));
    chk("rst_iw",         160'(iw),         160'(0));
    chk("rst_iw_xy",      160'({iw_x, iw_y, iw_last}), 160'(0));
    chk("rst_pulses",     160'({frame_done, frame_err}), 160'(0));
    rst = 1'b0;
    @(negedge clk);

    // Frame 1: config latched at sof, mid-frame change ignored
    clear_mon();
    send_frame(ADDI, 8'd7);
    first = 0;
    first[0] = {8'd2, 8'd1, 8'd0};
    first[1] = {8'd18, 8'd17, 8'd16};
    first[2] = {8'd34, 8'd33, 8'd32};
    if (cap.size() > 0) chk("f1_first_cellA_lit", 160'(cap[0].w.cellA), 160'(first));
    else                chk("f1_first_missing", 160'(0), 160'(1));
    check_frame("f1", ADDI, 8'd7, 1, 0);

    // Frame 2: backpressure on the first window
    clear_mon();
    fork
      send_frame(ADD, 8'd3);
      begin
        ok = 0;
        for (int i = 0; i < 60; i++) begin
          @(posedge clk); #1;
          if (iw_valid) begin ok = 1; break; end
        end
        chk("stall_seen", 160'(ok), 160'(1));
        iw_ready = 1'b0;
        snap = iw; sx = iw_x; sy = iw_y;
        chk("stall_centre", 160'({sx, sy}), 160'({3'd1, 2'd1}));
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          chk($sformatf("stall_iw%0d", k),    160'(iw), 160'(snap));
          chk($sformatf("stall_xy%0d", k),    160'({iw_x, iw_y}), 160'({sx, sy}));
          chk($sformatf("stall_valid%0d", k), 160'(iw_valid), 160'(1));
          chk($sformatf("stall_pready%0d", k), 160'(pix_ready), 160'(0));
        end
        @(posedge clk); #1;
        iw_ready = 1'b1;
      end
    join
    check_frame("f2", ADD, 8'd3, 1, 0);

    // Non-sof pixels while IDLE are dropped with an error pulse each
    clear_mon();
    for (int i = 0; i < 3; i++) begin
      send_px(i, 0, 1'b0, 1'b0);
      chk($sformatf("idle_nowin%0d", i), 160'(iw_valid), 160'(0));
    end
    idle_in(3);
    chk("idle_err", 160'(ne), 160'(3));
    chk("idle_windows", 160'(cap.size()), 160'(0));

    // Early sof at (2,1): old frame pixels then a full new frame
    clear_mon();
    cfg_opcode = MUL; cfg_user_a = 8'd50;
    for (int i = 0; i < 7; i++) send_px(i % W, i / W, (i == 0), 1'b1);
    send_frame(MAX, 8'd11);
    check_frame("early", MAX, 8'd11, 1, 1);

    // Async reset mid-frame with a window pending
    clear_mon();
    cfg_opcode = ADD; cfg_user_a = 8'd1;
    for (int i = 0; i < 2*W + 2; i++) send_px(i % W, i / W, (i == 0), 1'b0);
    iw_ready = 1'b0;
    send_px(2, 2, 1'b0, 1'b0);
    chk("prerst_valid", 160'(iw_valid), 160'(1));
    #2 rst = 1'b1;
    #1;
    chk("midrst_valid",  160'(iw_valid),  160'(0));
    chk("midrst_pready", 160'(pix_ready), 160'(1));
    @(negedge clk);
    rst = 1'b0;
    iw_ready = 1'b1;
    idle_in(1);
    clear_mon();
    send_frame(SUBI, 8'd42);
    check_frame("postrst", SUBI, 8'd42, 1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
